// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types, constants and the load-use hazard check for the fetch controller
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_IMWAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_X0    = 5'd0;

  localparam int FLUSH_DEPTH_MIN  = 1;
  localparam int FLUSH_DEPTH_MAX  = 4;
  localparam int IMEM_TIMEOUT_MIN = 2;
  localparam int IMEM_TIMEOUT_MAX = 1023;

  localparam int FLUSH_LEFT_W = $clog2(FLUSH_DEPTH_MAX);
  localparam int WAIT_W       = $clog2(IMEM_TIMEOUT_MAX + 1);

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  function automatic logic load_use(
    input logic       mem_read_e,
    input logic [4:0] rd_e,
    input logic [4:0] rs1_d,
    input logic [4:0] rs2_d,
    input logic       rs1_used_d,
    input logic       rs2_used_d
  );
    return mem_read_e && (rd_e != REG_X0) &&
           ((rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - fetch / IF-ID sequencing: branch flush, load-use stall, imem wait
module fetch_hazard_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH  = 1,
  parameter int IMEM_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrcE,
  input  logic             MemReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             Rs1UsedD,
  input  logic             Rs2UsedD,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             stallF_load_hazard,
  output logic             flushF_branch_hazard,
  output logic             stallD,
  output logic             flushE,
  output logic             imem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_e            state_q, state_d;
  logic [FLUSH_LEFT_W-1:0] flush_left_q, flush_left_d;
  logic                    imem_err_q, imem_err_d;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    lu;
  logic                    wait_inc, wait_clr, flush_inc;
  logic                    pc_write_c, stallF_c, flushF_c, stallD_c, flushE_c;

  assign lu = load_use(MemReadE, RdE, Rs1D, Rs2D, Rs1UsedD, Rs2UsedD);

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    pc_write_c   = 1'b0;
    stallF_c     = 1'b0;
    flushF_c     = 1'b0;
    stallD_c     = 1'b0;
    flushE_c     = 1'b0;
    wait_inc     = 1'b0;
    wait_clr     = 1'b0;
    flush_inc    = 1'b0;

    if (PCSrcE) begin
      pc_write_c = 1'b1;
      flushF_c   = 1'b1;
      flushE_c   = 1'b1;
      flush_inc  = 1'b1;
      if (FLUSH_DEPTH > 1) begin
        state_d      = ST_FLUSH;
        flush_left_d = FLUSH_LEFT_W'(FLUSH_DEPTH - 1);
      end else begin
        state_d      = ST_RUN;
        flush_left_d = '0;
      end
    end else if (state_q == ST_FLUSH) begin
      // decode already holds a NOP here, so a load-use match is stale
      pc_write_c   = imem_ready;
      flushF_c     = 1'b1;
      flush_left_d = flush_left_q - FLUSH_LEFT_W'(1);
      if (flush_left_d == '0) begin
        state_d = ST_RUN;
      end
    end else if (lu) begin
      stallF_c = 1'b1;
      stallD_c = 1'b1;
      flushE_c = 1'b1;
    end else if (!imem_ready) begin
      flushF_c = 1'b1;
      wait_inc = 1'b1;
      state_d  = ST_IMWAIT;
    end else begin
      pc_write_c = 1'b1;
      wait_clr   = 1'b1;
      state_d    = ST_RUN;
    end
  end

  assign imem_err_d = imem_err_q |
                      (wait_inc && (wait_cnt == WAIT_W'(IMEM_TIMEOUT - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
      imem_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      imem_err_q   <= imem_err_d;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (wait_clr),
    .inc_i   (wait_inc),
    .count_o (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .inc_i   (~pc_write_c),
    .count_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .inc_i   (flush_inc),
    .count_o (flush_cnt)
  );

  // outputs are forced low for the whole reset window, not just after the next edge
  assign pc_write             = pc_write_c & ~rst;
  assign stallF_load_hazard   = stallF_c   & ~rst;
  assign flushF_branch_hazard = flushF_c   & ~rst;
  assign stallD               = stallD_c   & ~rst;
  assign flushE               = flushE_c   & ~rst;
  assign imem_err             = imem_err_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - scoreboard bench for fetch_hazard_ctrl (default and small-parameter instances)
module tb_fetch_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       PCSrcE, MemReadE, Rs1UsedD, Rs2UsedD, imem_ready;
  logic [4:0] RdE, Rs1D, Rs2D;

  logic        a_pcw, a_stf, a_flf, a_std, a_fle, a_err;
  logic [15:0] a_sc, a_fc;
  logic        b_pcw, b_stf, b_flf, b_std, b_fle, b_err;
  logic [3:0]  b_sc, b_fc;

  fetch_hazard_ctrl #(.FLUSH_DEPTH(1), .IMEM_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .PCSrcE(PCSrcE), .MemReadE(MemReadE), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
    .imem_ready(imem_ready), .pc_write(a_pcw), .stallF_load_hazard(a_stf),
    .flushF_branch_hazard(a_flf), .stallD(a_std), .flushE(a_fle),
    .imem_err(a_err), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  fetch_hazard_ctrl #(.FLUSH_DEPTH(3), .IMEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .PCSrcE(PCSrcE), .MemReadE(MemReadE), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
    .imem_ready(imem_ready), .pc_write(b_pcw), .stallF_load_hazard(b_stf),
    .flushF_branch_hazard(b_flf), .stallD(b_std), .flushE(b_fle),
    .imem_err(b_err), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  // {pc_write, stallF, flushF, stallD, flushE}
  localparam logic [4:0] RUNO = 5'b10000;
  localparam logic [4:0] LUH  = 5'b01011;
  localparam logic [4:0] BR   = 5'b10101;
  localparam logic [4:0] FL   = 5'b10100;
  localparam logic [4:0] WT   = 5'b00100;
  localparam logic [4:0] ZR   = 5'b00000;

  typedef struct {
    int         id;
    bit         dut;
    logic [4:0] ctl;
    int         sc;
    int         fc;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_id  = 0;
  int   sc_exp[2];
  int   fc_exp[2];

  exp_t       m_e;
  logic [4:0] m_ctl;
  int         m_sc, m_fc;
  logic       m_err;

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        if (!m_e.dut) begin
          m_ctl = {a_pcw, a_stf, a_flf, a_std, a_fle};
          m_sc  = int'(a_sc);
          m_fc  = int'(a_fc);
          m_err = a_err;
        end else begin
          m_ctl = {b_pcw, b_stf, b_flf, b_std, b_fle};
          m_sc  = int'(b_sc);
          m_fc  = int'(b_fc);
          m_err = b_err;
        end
        n_vec++;
        if (m_ctl !== m_e.ctl) begin
          n_bad++;
          $display("FAIL v%0d dut%0d ctl got %b want %b", m_e.id, m_e.dut, m_ctl, m_e.ctl);
        end
        if (m_sc != m_e.sc) begin
          n_bad++;
          $display("FAIL v%0d dut%0d stall_cnt got %0d want %0d", m_e.id, m_e.dut, m_sc, m_e.sc);
        end
        if (m_fc != m_e.fc) begin
          n_bad++;
          $display("FAIL v%0d dut%0d flush_cnt got %0d want %0d", m_e.id, m_e.dut, m_fc, m_e.fc);
        end
        if (m_err !== m_e.err) begin
          n_bad++;
          $display("FAIL v%0d dut%0d imem_err got %b want %b", m_e.id, m_e.dut, m_err, m_e.err);
        end
      end
    end
  end

  task automatic push(input bit d, input logic [4:0] ctl, input logic err);
    exp_t e;
    e.id  = n_id;
    e.dut = d;
    e.ctl = ctl;
    e.sc  = sc_exp[d];
    e.fc  = fc_exp[d];
    e.err = err;
    n_id++;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit d, input logic pcs, input logic mr, input logic [4:0] rde,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic rdy, input logic [4:0] ctl, input logic err);
    int mx;
    @(posedge clk);
    #1;
    if (d) rst_b = 1'b0;
    else   rst_a = 1'b0;
    PCSrcE = pcs; MemReadE = mr; RdE = rde;
    Rs1D = rs1; Rs1UsedD = u1; Rs2D = rs2; Rs2UsedD = u2;
    imem_ready = rdy;
    push(d, ctl, err);
    mx = d ? 15 : 65535;
    if (!ctl[4] && sc_exp[d] < mx) sc_exp[d]++;
    if (pcs && fc_exp[d] < mx) fc_exp[d]++;
  endtask

  task automatic idle(input bit d, input logic err);
    cyc(d, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, RUNO, err);
  endtask

  task automatic imwait(input bit d, input logic err);
    cyc(d, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, WT, err);
  endtask

  task automatic rst_cyc(input bit d);
    @(posedge clk);
    #1;
    if (d) rst_b = 1'b1;
    else   rst_a = 1'b1;
    sc_exp[d] = 0;
    fc_exp[d] = 0;
    push(d, ZR, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    PCSrcE = 1'b0; MemReadE = 1'b0; RdE = '0; Rs1D = '0; Rs2D = '0;
    Rs1UsedD = 1'b0; Rs2UsedD = 1'b0; imem_ready = 1'b1;
    sc_exp[0] = 0; sc_exp[1] = 0; fc_exp[0] = 0; fc_exp[1] = 0;
    repeat (2) @(posedge clk);

    // defaults: FLUSH_DEPTH=1, IMEM_TIMEOUT=64, CNT_W=16
    rst_cyc(0);
    idle(0, 0);
    cyc(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, LUH, 0);
    idle(0, 0);
    cyc(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 1, RUNO, 0);
    cyc(0, 0, 1, 5'd7, 5'd0, 1, 5'd7, 0, 1, RUNO, 0);
    cyc(0, 0, 1, 5'd7, 5'd0, 1, 5'd7, 1, 1, LUH, 0);
    cyc(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, BR, 0);
    idle(0, 0);
    repeat (4) imwait(0, 0);
    idle(0, 0);
    imwait(0, 0);
    cyc(0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, LUH, 0);
    imwait(0, 0);
    idle(0, 0);
    imwait(0, 0);
    cyc(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, BR, 0);
    idle(0, 0);
    imwait(0, 0);
    imwait(0, 0);
    rst_cyc(0);
    idle(0, 0);

    // FLUSH_DEPTH=3, IMEM_TIMEOUT=4, CNT_W=4
    rst_cyc(1);
    rst_a = 1'b1;
    idle(1, 0);
    cyc(1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, BR, 0);
    cyc(1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, FL, 0);
    cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, WT, 0);
    idle(1, 0);
    cyc(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, BR, 0);
    cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, FL, 0);
    cyc(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, BR, 0);
    cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, FL, 0);
    cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, FL, 0);
    idle(1, 0);
    repeat (4) imwait(1, 0);
    imwait(1, 1);
    idle(1, 1);
    idle(1, 1);
    repeat (20) imwait(1, 1);
    idle(1, 1);
    cyc(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, BR, 1);
    cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, FL, 1);
    rst_cyc(1);
    idle(1, 0);
    idle(1, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Sequencing controller for the fetch stage and the IF/ID register.
- Generates pc_write, stallF_load_hazard, flushF_branch_hazard, plus the companion decode stall and execute bubble.
- Inputs it arbitrates between: branch redirects from Execute, load-use hazards detected in Decode, and a multi-cycle instruction memory (imem_ready).
- Also keeps saturating performance counters and a sticky instruction-memory timeout flag.

Parameters:
- FLUSH_DEPTH, 1, cycles flushF_branch_hazard stays asserted per redirect (legal 1..4).
- IMEM_TIMEOUT, 64, consecutive imem_ready=0 cycles that set imem_err (legal 2..1023).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- PCSrcE  input  1  branch/jump taken in Execute
- MemReadE  input  1  instruction in Execute is a load
- RdE  input  5  destination register of the Execute instruction
- Rs1D  input  5  source register 1 of the Decode instruction
- Rs2D  input  5  source register 2 of the Decode instruction
- Rs1UsedD  input  1  Decode instruction reads Rs1
- Rs2UsedD  input  1  Decode instruction reads Rs2
- imem_ready  input  1  instruction memory data valid this cycle
- pc_write  output  1  PC register load enable
- stallF_load_hazard  output  1  hold IF/ID register
- flushF_branch_hazard  output  1  load NOP (0x00000013) into IF/ID
- stallD  output  1  hold the decode stage
- flushE  output  1  insert a bubble into ID/EX
- imem_err  output  1  sticky instruction-memory timeout
- stall_cnt  output  CNT_W  cycles with pc_write=0
- flush_cnt  output  CNT_W  branch redirects taken

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN; flush_left=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, imem_err=0.
  - All control outputs forced to 0 while rst=1.
  - Reset mid-operation abandons any FLUSH or IMWAIT immediately.
- Load-use hazard, combinational: lu = MemReadE & (RdE!=0) & ((Rs1UsedD & Rs1D==RdE) | (Rs2UsedD & Rs2D==RdE)).
- States: RUN, FLUSH, IMWAIT. Control outputs are Mealy (state + inputs), zero added latency.
- Priority every cycle, highest first:
  1. PCSrcE:
     - Outputs: pc_write=1, flushF=1, flushE=1, stallF=0, stallD=0.
     - flush_cnt += 1.
     - If FLUSH_DEPTH>1: next state FLUSH with flush_left=FLUSH_DEPTH-1; else RUN.
     - Accepted in any state; it restarts the FLUSH count.
  2. State FLUSH (no new PCSrcE):
     - Outputs: pc_write=imem_ready, flushF=1, flushE=0.
     - flush_left decrements; return to RUN when it reaches 0.
     - lu is ignored in this state (decode holds a NOP).
  3. lu in RUN or IMWAIT:
     - Outputs: pc_write=0, stallF=1, stallD=1, flushE=1, flushF=0.
     - State unchanged.
     - A hazard lasts exactly one cycle because the bubble clears MemReadE. The controller does not enforce this.
  4. imem_ready=0 in RUN or IMWAIT:
     - Outputs: pc_write=0, flushF=1, others 0.
     - Next state IMWAIT; wait_cnt += 1 (saturating).
     - When wait_cnt reaches IMEM_TIMEOUT, imem_err=1 and holds until reset.
  5. Otherwise: pc_write=1, all else 0; state=RUN; wait_cnt=0.
- Invariants:
  - stallF and flushF never both 1.
  - stallF implies stallD.
  - pc_write=0 implies a stall or flush is active.
- Counters:
  - stall_cnt increments on every post-reset cycle with pc_write=0.
  - Both counters saturate at all-ones and never wrap.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - the state enum (RUN, FLUSH, IMWAIT);
  - NOP_INSTR=32'h00000013;
  - REG_X0=5'd0;
  - flush-depth and timeout legality bounds.
- One natural sub-module: sat_counter (parameterised width, increment enable, async active-high reset). Instantiated for stall_cnt, flush_cnt and wait_cnt.

Test Plan:
- Load-use: MemReadE=1, RdE=5, Rs1D=5, Rs1UsedD=1 for one cycle -> that cycle pc_write=0, stallF=1, stallD=1, flushE=1, flushF=0; next cycle pc_write=1; stall_cnt=1.
- x0 and unused operands: RdE=0 with Rs1D=0, Rs1UsedD=1; then RdE=7 with Rs2D=7, Rs2UsedD=0 -> no stall in either case.
- Branch beats load-use: PCSrcE=1 together with a matching lu -> pc_write=1, flushF=1, flushE=1, stallF=0; flush_cnt=1. With FLUSH_DEPTH=3, flushF stays 1 for 3 cycles total.
- IMEM wait: imem_ready=0 for 4 cycles -> pc_write=0, flushF=1 each cycle, stall_cnt=4, imem_err=0. With IMEM_TIMEOUT=4 and a 5-cycle wait -> imem_err=1 and stays 1 after imem_ready returns.
- Reset: assert rst asynchronously mid-FLUSH and mid-IMWAIT -> all outputs 0 immediately, counters 0; first cycle after release is normal RUN.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds.
